// File: rtl/saw_receiver.sv
// Stop-and-wait ARQ receiver: bit-serial CRC check, duplicate filter, valid/ready delivery, one-cycle ACK/NAK strobe.
// Latency: CMP in cycle PAYLOAD_BW+1 after acceptance; frame_ready is low outside IDLE; data held until data_ready.
module saw_receiver #(
    parameter int                PAYLOAD_BW = 10,
    parameter int                CRC_BW     = 8,
    parameter logic [CRC_BW-1:0] POLY       = 8'h07,
    parameter int                ACK_BW     = 3,
    parameter int                CNT_BW     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PAYLOAD_BW+CRC_BW-1:0] frame_in,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    output logic [PAYLOAD_BW-2:0]        data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [ACK_BW-1:0]            ack_out,
    output logic [CNT_BW-1:0]            err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_CRC, S_CMP, S_DELIVER} state_t;

    state_t                  state_q;
    logic [PAYLOAD_BW-1:0]   payload_q;
    logic [PAYLOAD_BW-1:0]   shift_q;
    logic [CRC_BW-1:0]       crc_rx_q;
    logic [CRC_BW-1:0]       crc_acc_q;
    logic [CRC_BW-1:0]       crc_acc_d;
    logic [CNT_BW-1:0]       bit_cnt_q;
    logic [CNT_BW-1:0]       err_cnt_q;
    logic                    exp_seq_q;
    logic                    data_valid_q;
    logic [PAYLOAD_BW-2:0]   data_out_q;
    logic [ACK_BW-1:0]       ack_q;
    logic                    fb;

    // shift_q feeds payload bits MSB first, so the sequence bit enters the CRC first
    always_comb begin
        fb        = crc_acc_q[CRC_BW-1] ^ shift_q[PAYLOAD_BW-1];
        crc_acc_d = {crc_acc_q[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            payload_q    <= '0;
            shift_q      <= '0;
            crc_rx_q     <= '0;
            crc_acc_q    <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
            exp_seq_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            ack_q        <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (frame_valid) begin
                        payload_q <= frame_in[CRC_BW +: PAYLOAD_BW];
                        shift_q   <= frame_in[CRC_BW +: PAYLOAD_BW];
                        crc_rx_q  <= frame_in[CRC_BW-1:0];
                        crc_acc_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_CRC;
                    end
                end
                S_CRC: begin
                    crc_acc_q <= crc_acc_d;
                    shift_q   <= {shift_q[PAYLOAD_BW-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_BW'(PAYLOAD_BW-1)) begin
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (crc_acc_q != crc_rx_q) begin
                        ack_q <= {1'b1, 1'b1, exp_seq_q};
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else if (payload_q[PAYLOAD_BW-1] != exp_seq_q) begin
                        // Duplicate: re-acknowledge so the transmitter can move on
                        ack_q   <= {1'b1, 1'b0, payload_q[PAYLOAD_BW-1]};
                        state_q <= S_IDLE;
                    end else begin
                        data_out_q   <= payload_q[PAYLOAD_BW-2:0];
                        data_valid_q <= 1'b1;
                        state_q      <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (data_ready) begin
                        data_valid_q <= 1'b0;
                        exp_seq_q    <= ~exp_seq_q;
                        ack_q        <= {1'b1, 1'b0, payload_q[PAYLOAD_BW-1]};
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign frame_ready = (state_q == S_IDLE);
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign ack_out     = ack_q;
    assign err_cnt     = err_cnt_q;

endmodule
